// File: rtl/conv_pixel_streamer.sv
// Frame-to-pixel serialiser feeding the convolution line buffer: captures a whole
// frame in one handshake, streams it highest index first, flushes, then pulses done.
module conv_pixel_streamer #(
    parameter int BitSize     = 4,
    parameter int N           = 3,
    parameter int ImageWidth  = 4,
    parameter int FlushCycles = ImageWidth*(N-1)/2 + (N-1)/2 + 1
) (
    input  logic                                          clk,
    input  logic                                          res,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [ImageWidth*ImageWidth-1:0][BitSize-1:0] in_image,
    input  logic                                          out_ready,
    output logic                                          out_valid,
    output logic [BitSize-1:0]                            out_data,
    output logic                                          out_done
);
    localparam int WW = ImageWidth*ImageWidth;
    localparam int IW = (WW > 1) ? $clog2(WW) : 1;
    localparam int CW = $clog2(FlushCycles+1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WW-1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FlushCycles-1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t                       state, state_nx;
    logic [WW-1:0][BitSize-1:0]   frame, frame_nx;
    logic [IW-1:0]                idx, idx_nx;
    logic [CW-1:0]                cnt, cnt_nx;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
            frame <= '0;
            idx   <= IDX_LAST;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            frame <= frame_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        frame_nx = frame;
        idx_nx   = idx;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    frame_nx = in_image;
                    idx_nx   = IDX_LAST;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                // A stalled cycle holds idx so the same pixel is re-presented.
                if (out_ready) begin
                    if (idx != '0) begin
                        idx_nx = idx - IW'(1);
                    end else begin
                        cnt_nx   = '0;
                        state_nx = FLUSH;
                    end
                end
            end
            FLUSH: begin
                cnt_nx = cnt + CW'(1);
                if (cnt == CNT_LAST) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == STREAM);
    assign out_done  = (state == DONE);
    assign out_data  = (state == STREAM) ? frame[idx] : '0;

endmodule

// File: tb/tb_conv_pixel_streamer.sv
// Scoreboard bench for conv_pixel_streamer: default-parameter instance for timing,
// stall, back-to-back and reset-abort cases, plus an N=5/ImageWidth=6 instance.
module tb_conv_pixel_streamer;
    typedef logic [15:0][3:0] frame_t;
    typedef logic [35:0][3:0] frame_b_t;
    localparam int WW = 16;
    localparam int FC = 6;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       in_valid = 1'b0, in_ready, out_ready = 1'b1, out_valid, out_done;
    frame_t     in_image = '0;
    logic [3:0] out_data;

    logic       b_in_valid = 1'b0, b_in_ready, b_out_ready = 1'b1, b_out_valid, b_out_done;
    frame_b_t   b_in_image = '0;
    logic [3:0] b_out_data;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] q[$];
    logic [3:0] qb[$];

    always #5 clk = ~clk;

    conv_pixel_streamer dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
        .in_image(in_image), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_done(out_done)
    );

    conv_pixel_streamer #(.BitSize(4), .N(5), .ImageWidth(6)) dut_b (
        .clk(clk), .res(res), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_image(b_in_image), .out_ready(b_out_ready), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_done(b_out_done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Called at a negedge: that cycle is cycle 0 (capture edge at its end).
    task automatic run_frame(input frame_t img, input int stall_lo, input int stall_hi,
                             input int abort_at, input bit keep_valid);
        int stalls, exp_done;
        stalls   = (stall_hi >= stall_lo) ? stall_hi - stall_lo + 1 : 0;
        exp_done = 1 + WW + FC + stalls;
        in_image  = img;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < WW; i++) q.push_back(img[WW-1-i]);
        chk("rdy_cap", in_ready, 1);
        chk("vld_cap", out_valid, 0);
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            in_valid  = keep_valid;
            if (keep_valid) in_image = {$urandom(), $urandom()};
            out_ready = !(c >= stall_lo && c <= stall_hi);
            if (out_valid) begin
                if (q.size() == 0) chk("pix_extra", 1, 0);
                else chk("pix", out_data, q[0]);
                if (out_ready && q.size() != 0) void'(q.pop_front());
            end else begin
                chk("data_zero", out_data, 0);
            end
            chk("vld", out_valid, (c <= WW + stalls) ? 1 : 0);
            chk("done", out_done, (c == exp_done) ? 1 : 0);
            if (c == abort_at) begin
                res = 1'b1;
                #1;
                chk("abort_vld", out_valid, 0);
                chk("abort_rdy", in_ready, 1);
                q.delete();
                @(negedge clk);
                @(negedge clk);
                res       = 1'b0;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("abort_nodone", out_done, 0);
                    chk("abort_idle", in_ready, 1);
                end
                return;
            end
        end
        chk("rdy_ret", in_ready, 1);
        chk("q_empty", q.size(), 0);
    endtask

    initial begin
        int     seq1[16] = '{7,2,2,15, 8,8,15,7, 15,2,8,8, 15,8,8,8};
        int     tmp;
        frame_t f1, fr;
        frame_b_t fb;

        for (int i = 0; i < 16; i++) begin
            tmp = seq1[i];
            f1[15-i] = tmp[3:0];
        end

        @(negedge clk);
        chk("rst_vld", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_done", out_done, 0);
        chk("rst_rdy", in_ready, 1);
        res = 1'b0;
        @(negedge clk);

        run_frame(f1, 0, -1, 0, 1'b0);                 // plain stream
        @(negedge clk);
        run_frame(f1, 3, 5, 0, 1'b0);                  // stall cycles 3-5
        @(negedge clk);
        run_frame(f1, 0, -1, 0, 1'b1);                 // in_valid held, garbage during STREAM
        fr = {$urandom(), $urandom()};
        run_frame(fr, 0, -1, 0, 1'b0);                 // captured on the cycle-24 edge
        @(negedge clk);
        fr = {$urandom(), $urandom()};
        run_frame(fr, 0, -1, 10, 1'b0);                // abort mid-stream
        run_frame(f1, 0, -1, 0, 1'b0);
        @(negedge clk);
        fr = {$urandom(), $urandom()};
        run_frame(fr, 0, -1, 19, 1'b0);                // abort mid-flush
        fr = {$urandom(), $urandom()};
        run_frame(fr, 0, -1, 0, 1'b0);

        @(negedge clk);
        for (int i = 0; i < 36; i++) fb[i] = 4'($urandom());
        for (int i = 0; i < 36; i++) qb.push_back(fb[35-i]);
        b_in_image = fb;
        b_in_valid = 1'b1;
        chk("b_rdy_cap", b_in_ready, 1);
        for (int c = 1; c <= 54; c++) begin
            @(negedge clk);
            b_in_valid = 1'b0;
            if (b_out_valid) begin
                if (qb.size() == 0) chk("b_pix_extra", 1, 0);
                else chk("b_pix", b_out_data, qb.pop_front());
            end
            chk("b_vld", b_out_valid, (c <= 36) ? 1 : 0);
            chk("b_done", b_out_done, (c == 52) ? 1 : 0);
        end
        chk("b_q_empty", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
